// File: rtl/param_sum_checker.sv
// param_sum_checker
//   Sequential self-checking accumulator. A run sums CHANNELS operands of
//   WIDTH bits, one per clock, then compares the total against a captured
//   expected value and flags a mismatch.
//
//   Build option: define PARAM_SUM_CHECKER_SATURATE_EN to make every add
//   clamp at 2^WIDTH-1 instead of wrapping modulo 2^WIDTH.
//
// Parameters
//   WIDTH     operand/sum width (>=2)
//   CHANNELS  operands per run (>=1)
//   STICKY    1: ERROR holds until reset; 0: ERROR tracks the latest compare
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      run request, sampled only in IDLE
//   operands   packed operands, channel i at [i*WIDTH +: WIDTH]
//   expected   reference total, captured with operands on accepted start
//   busy       high while accumulating or checking
//   sum        running / final sum, held in IDLE
//   done       one-cycle pulse when the comparison completes
//   ERROR      mismatch flag
//   err_count  mismatching runs, saturating at 255
//
// States
//   IDLE  | waiting for start, sum holds the last result
//   ACCUM | adding one captured operand per cycle
//   CHECK | comparing sum with captured expected, pulsing done
`timescale 1ns/1ps
module param_sum_checker #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int STICKY   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CHANNELS*WIDTH-1:0] operands,
  input  logic [WIDTH-1:0]          expected,
  output logic                      busy,
  output logic [WIDTH-1:0]          sum,
  output logic                      done,
  output logic                      ERROR,
  output logic [7:0]                err_count
);

  localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, CHECK} state_t;

  state_t                    state, state_d;
  logic [CHANNELS*WIDTH-1:0] ops_q, ops_d;
  logic [WIDTH-1:0]          exp_q, exp_d;
  logic [IDXW-1:0]           idx, idx_d;
  logic [WIDTH-1:0]          sum_d;
  logic                      busy_d, done_d, error_d;
  logic [7:0]                cnt_d;
  logic [WIDTH-1:0]          op_cur;
  logic [WIDTH-1:0]          add_res;

  // Channel select written as a compare loop so the index never needs a
  // variable-width part select.
  always_comb begin
    op_cur = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx == IDXW'(i)) op_cur = ops_q[i*WIDTH +: WIDTH];
    end
  end

`ifdef PARAM_SUM_CHECKER_SATURATE_EN
  logic [WIDTH:0] add_full;
  // Clamp on carry out; once at max, adding any operand carries again (or
  // adds zero), so the sum stays pinned for the rest of the run.
  always_comb begin
    add_full = {1'b0, sum} + {1'b0, op_cur};
    add_res  = add_full[WIDTH] ? '1 : add_full[WIDTH-1:0];
  end
`else
  always_comb add_res = sum + op_cur;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ops_q     <= '0;
      exp_q     <= '0;
      idx       <= '0;
      sum       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ERROR     <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state     <= state_d;
      ops_q     <= ops_d;
      exp_q     <= exp_d;
      idx       <= idx_d;
      sum       <= sum_d;
      busy      <= busy_d;
      done      <= done_d;
      ERROR     <= error_d;
      err_count <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    ops_d   = ops_q;
    exp_d   = exp_q;
    idx_d   = idx;
    sum_d   = sum;
    busy_d  = busy;
    done_d  = 1'b0;
    error_d = ERROR;
    cnt_d   = err_count;
    case (state)
      IDLE: begin
        if (start) begin
          ops_d   = operands;
          exp_d   = expected;
          sum_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        sum_d = add_res;
        idx_d = idx + IDXW'(1);
        if (idx == LAST_IDX) begin
          idx_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (sum != exp_q) begin
          error_d = 1'b1;
          if (err_count != 8'hFF) cnt_d = err_count + 8'd1;
        end else if (STICKY == 0) begin
          error_d = 1'b0;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_param_sum_checker.sv
`timescale 1ns/1ps
module tb_param_sum_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance 0: WIDTH 32, CHANNELS 2, STICKY 1
  logic        start_a;
  logic [63:0] ops_a;
  logic [31:0] exp_a, sum_a;
  logic        busy_a, done_a, err_a;
  logic [7:0]  cnt_a;
  // instance 1: WIDTH 8, CHANNELS 2, STICKY 0
  logic        start_b;
  logic [15:0] ops_b;
  logic [7:0]  exp_b, sum_b;
  logic        busy_b, done_b, err_b;
  logic [7:0]  cnt_b;
  // instance 2: WIDTH 8, CHANNELS 4, STICKY 1
  logic        start_c;
  logic [31:0] ops_c;
  logic [7:0]  exp_c, sum_c;
  logic        busy_c, done_c, err_c;
  logic [7:0]  cnt_c;
  // instance 3: WIDTH 8, CHANNELS 1, STICKY 1
  logic        start_d;
  logic [7:0]  ops_d;
  logic [7:0]  exp_d, sum_d;
  logic        busy_d, done_d, err_d;
  logic [7:0]  cnt_d;

  param_sum_checker #(.WIDTH(32), .CHANNELS(2), .STICKY(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .operands(ops_a), .expected(exp_a),
    .busy(busy_a), .sum(sum_a), .done(done_a), .ERROR(err_a), .err_count(cnt_a));
  param_sum_checker #(.WIDTH(8), .CHANNELS(2), .STICKY(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .operands(ops_b), .expected(exp_b),
    .busy(busy_b), .sum(sum_b), .done(done_b), .ERROR(err_b), .err_count(cnt_b));
  param_sum_checker #(.WIDTH(8), .CHANNELS(4), .STICKY(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .operands(ops_c), .expected(exp_c),
    .busy(busy_c), .sum(sum_c), .done(done_c), .ERROR(err_c), .err_count(cnt_c));
  param_sum_checker #(.WIDTH(8), .CHANNELS(1), .STICKY(1)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .operands(ops_d), .expected(exp_d),
    .busy(busy_d), .sum(sum_d), .done(done_d), .ERROR(err_d), .err_count(cnt_d));

  int checks = 0;
  int errors = 0;
  int wid[4] = '{32, 8, 8, 8};
  int chn[4] = '{2, 2, 4, 1};
  int stk[4] = '{1, 0, 1, 1};
  bit m_err[4];
  int m_cnt[4];
  longint cur_ops[4];

  task automatic check(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint mask(int w);
    return (longint'(1) << wid[w]) - 1;
  endfunction

  // Reference: plain integer sum of the channels, then wrap or clamp.
  function automatic longint model_sum(int w);
    longint s = 0;
    for (int i = 0; i < chn[w]; i++) begin
      s = s + cur_ops[i];
`ifdef PARAM_SUM_CHECKER_SATURATE_EN
      if (s > mask(w)) s = mask(w);
`else
      s = s & mask(w);
`endif
    end
    return s;
  endfunction

  function automatic logic obs_done(int w);
    case (w)
      0: return done_a;
      1: return done_b;
      2: return done_c;
      default: return done_d;
    endcase
  endfunction
  function automatic logic obs_busy(int w);
    case (w)
      0: return busy_a;
      1: return busy_b;
      2: return busy_c;
      default: return busy_d;
    endcase
  endfunction
  function automatic logic obs_err(int w);
    case (w)
      0: return err_a;
      1: return err_b;
      2: return err_c;
      default: return err_d;
    endcase
  endfunction
  function automatic longint obs_sum(int w);
    case (w)
      0: return longint'(sum_a);
      1: return longint'(sum_b);
      2: return longint'(sum_c);
      default: return longint'(sum_d);
    endcase
  endfunction
  function automatic longint obs_cnt(int w);
    case (w)
      0: return longint'(cnt_a);
      1: return longint'(cnt_b);
      2: return longint'(cnt_c);
      default: return longint'(cnt_d);
    endcase
  endfunction

  task automatic set_start(int w, logic v);
    case (w)
      0: start_a = v;
      1: start_b = v;
      2: start_c = v;
      default: start_d = v;
    endcase
  endtask

  task automatic set_ops(longint o0, longint o1, longint o2, longint o3);
    cur_ops[0] = o0; cur_ops[1] = o1; cur_ops[2] = o2; cur_ops[3] = o3;
  endtask

  task automatic drive(int w, longint e);
    case (w)
      0: begin ops_a = {cur_ops[1][31:0], cur_ops[0][31:0]}; exp_a = e[31:0]; end
      1: begin ops_b = {cur_ops[1][7:0], cur_ops[0][7:0]}; exp_b = e[7:0]; end
      2: begin
        ops_c = {cur_ops[3][7:0], cur_ops[2][7:0], cur_ops[1][7:0], cur_ops[0][7:0]};
        exp_c = e[7:0];
      end
      default: begin ops_d = cur_ops[0][7:0]; exp_d = e[7:0]; end
    endcase
  endtask

  task automatic update_model(int w, longint e, output longint s);
    s = model_sum(w);
    if (s != e) begin
      m_err[w] = 1'b1;
      if (m_cnt[w] < 255) m_cnt[w]++;
    end else if (stk[w] == 0) begin
      m_err[w] = 1'b0;
    end
  endtask

  // Edges counted after the accepting edge until done is seen; 0 on timeout.
  task automatic wait_done(int w, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (obs_done(w)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_result(int w, string tag, longint s);
    check({tag, "_sum"}, obs_sum(w), s);
    check({tag, "_err"}, longint'(obs_err(w)), longint'(m_err[w]));
    check({tag, "_cnt"}, obs_cnt(w), longint'(m_cnt[w]));
    check({tag, "_idle"}, longint'(obs_busy(w)), 0);
  endtask

  task automatic do_run(int w, longint e, string tag);
    int n;
    longint s;
    drive(w, e);
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    check({tag, "_busy"}, longint'(obs_busy(w)), 1);
    update_model(w, e, s);
    // Inputs are free to change after capture.
    for (int i = 0; i < 4; i++) cur_ops[i] = longint'($urandom) & mask(w);
    drive(w, longint'($urandom) & mask(w));
    wait_done(w, n);
    check({tag, "_lat"}, n, chn[w] + 1);
    check_result(w, tag, s);
    @(posedge clk); #1;
    check({tag, "_pulse"}, longint'(obs_done(w)), 0);
    check({tag, "_hold"}, obs_sum(w), s);
  endtask

  initial begin
    int n;
    int w;
    longint s;
    longint e;
    bit saw_done;

    rst = 1'b1;
    start_a = 0; start_b = 0; start_c = 0; start_d = 0;
    ops_a = '0; ops_b = '0; ops_c = '0; ops_d = '0;
    exp_a = '0; exp_b = '0; exp_c = '0; exp_d = '0;
    for (int i = 0; i < 4; i++) begin m_err[i] = 0; m_cnt[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_busy", longint'(obs_busy(i)), 0);
      check("rst_sum", obs_sum(i), 0);
      check("rst_done", longint'(obs_done(i)), 0);
      check("rst_err", longint'(obs_err(i)), 0);
      check("rst_cnt", obs_cnt(i), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // basic match / mismatch / sticky on a 2x32 checker
    set_ops(5, 2, 0, 0); do_run(0, 7, "a_match");
    set_ops(5, 2, 0, 0); do_run(0, 8, "a_miss");
    set_ops(5, 2, 0, 0); do_run(0, 7, "a_sticky");

    // non-sticky checker clears ERROR on a matching run
    set_ops(5, 2, 0, 0); do_run(1, 8, "b_miss");
    set_ops(5, 2, 0, 0); do_run(1, 7, "b_clear");
    // overflow: wraps to 44, or clamps to 255 in the saturating build
    set_ops(100, 200, 0, 0); do_run(1, 44, "b_ovf44");
    set_ops(100, 200, 0, 0); do_run(1, 255, "b_ovf255");

    // start held high across a 4-channel run: one run, then a restart
    set_ops(1, 2, 3, 4);
    drive(2, 10);
    set_start(2, 1'b1);
    @(posedge clk); #1;
    check("hold_busy", longint'(busy_c), 1);
    update_model(2, 10, s);
    wait_done(2, n);
    check("hold_lat", n, 5);
    check("hold_sum", longint'(sum_c), 10);
    @(posedge clk); #1;
    check("hold_restart", longint'(busy_c), 1);
    set_start(2, 1'b0);
    update_model(2, 10, s);
    wait_done(2, n);
    check("hold2_lat", n, 5);
    check_result(2, "hold2", s);

    // asynchronous reset in the middle of ACCUM
    set_ops(1, 2, 3, 4);
    drive(2, 10);
    set_start(2, 1'b1);
    @(posedge clk); #1;
    set_start(2, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", longint'(busy_c), 0);
    check("arst_sum", longint'(sum_c), 0);
    check("arst_done", longint'(done_c), 0);
    check("arst_err", longint'(err_a), 0);
    check("arst_cnt", longint'(cnt_a), 0);
    for (int i = 0; i < 4; i++) begin m_err[i] = 0; m_cnt[i] = 0; end
    @(posedge clk); #1;
    rst = 1'b0;
    saw_done = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_c) saw_done = 1;
    end
    check("arst_nodone", longint'(saw_done), 0);
    set_ops(1, 2, 3, 4); do_run(2, 10, "arst_after");

    // random runs against the reference model
    for (int k = 0; k < 30; k++) begin
      w = int'($urandom_range(0, 2));
      for (int i = 0; i < 4; i++) cur_ops[i] = longint'($urandom) & mask(w);
      e = model_sum(w);
      if ($urandom_range(0, 1) == 0) e = longint'($urandom) & mask(w);
      do_run(w, e, "rand");
    end

    // error counter saturation
    for (int k = 0; k < 256; k++) begin
      set_ops(1, 0, 0, 0);
      do_run(3, 0, "satcnt");
    end
    check("sat_cnt_final", longint'(cnt_d), 255);
    check("sat_err_final", longint'(err_d), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
